flag_stack_register: RTL and testbench

- Parametrised successor to the 3-bit condition-flag register.
- Holds NFLAGS condition flags with independent per-flag write enables.
- Adds a DEPTH-entry save/restore stack so flags are preserved across interrupt entry and return, and across nested calls.
- Sits between the ALU flag outputs and branch-condition logic; the interrupt/call controller drives push/pop.

---
 rtl/flag_stack_register_if.sv | 43 ++++
 rtl/flag_stack_register.sv | 117 +++++++++++
 tb/tb_flag_stack_register.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/flag_stack_register_if.sv
// flag_stack_register_if
//   Bundles the data/control signals of flag_stack_register.
//   master : interrupt/call controller + ALU side (drives flags_in,
//            flags_wen, push, pop; observes the flag/stack status)
//   slave  : the flag stack register itself
//   Parameters NFLAGS / DEPTH must match those of the attached register.
//   Optional macro FLAG_STACK_FWD_EN adds flags_fwd (next-edge flag value).
interface flag_stack_register_if #(
    parameter int NFLAGS = 3,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [NFLAGS-1:0] flags_in;
    logic [NFLAGS-1:0] flags_wen;
    logic              push;
    logic              pop;
    logic [NFLAGS-1:0] flags;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              ovf_err;
    logic              unf_err;
`ifdef FLAG_STACK_FWD_EN
    logic [NFLAGS-1:0] flags_fwd;
`endif

    modport master (
        output flags_in, flags_wen, push, pop,
        input  flags, count, full, empty, ovf_err, unf_err
`ifdef FLAG_STACK_FWD_EN
        , input flags_fwd
`endif
    );

    modport slave (
        input  flags_in, flags_wen, push, pop,
        output flags, count, full, empty, ovf_err, unf_err
`ifdef FLAG_STACK_FWD_EN
        , output flags_fwd
`endif
    );
endinterface

// File: rtl/flag_stack_register.sv
// flag_stack_register
//   NFLAGS condition flags with per-flag write enables, plus a DEPTH-entry
//   LIFO save/restore stack used across interrupt entry/return and calls.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous, active-low reset
//     bus  : flag_stack_register_if.slave
//            flags_in/flags_wen : masked flag write from the ALU
//            push/pop           : save / restore (both = exchange with top)
//            flags              : architectural flags (registered)
//            count/full/empty   : stack occupancy (registered)
//            ovf_err/unf_err    : sticky push-while-full / pop-while-empty
//   Optional macro FLAG_STACK_FWD_EN: drives bus.flags_fwd, the value flags
//   will take at the next edge, so a same-cycle branch needs no stall.
module flag_stack_register #(
    parameter int NFLAGS = 3,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    flag_stack_register_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NFLAGS-1:0] flags_r;
    logic [CW-1:0]     count_r;
    logic              full_r;
    logic              empty_r;
    logic              ovf_r;
    logic              unf_r;
    logic [NFLAGS-1:0] stack [DEPTH];

    logic [NFLAGS-1:0] masked_flags;
    logic [NFLAGS-1:0] flags_nx;
    logic [CW-1:0]     count_nx;
    logic              stk_we;
    logic [IW-1:0]     stk_idx;
    logic [IW-1:0]     top_idx;
    logic [IW-1:0]     push_idx;
    logic              ovf_set;
    logic              unf_set;

    always_comb begin
        top_idx      = IW'(count_r - CW'(1));
        push_idx     = IW'(count_r);
        masked_flags = (flags_r & ~bus.flags_wen) | (bus.flags_in & bus.flags_wen);

        flags_nx = masked_flags;
        count_nx = count_r;
        stk_we   = 1'b0;
        stk_idx  = push_idx;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;

        if (bus.pop && !empty_r) begin
            // Restore wins over any flag write. With push also set this is
            // an exchange: the pre-edge flags take the top slot in place.
            flags_nx = stack[top_idx];
            stk_idx  = top_idx;
            if (bus.push) begin
                stk_we = 1'b1;
            end else begin
                count_nx = count_r - CW'(1);
            end
        end else if (bus.push) begin
            // Also covers push+pop on an empty stack (plain push, no unf_err).
            if (!full_r) begin
                stk_we   = 1'b1;
                count_nx = count_r + CW'(1);
            end else begin
                ovf_set = 1'b1;
            end
        end else if (bus.pop) begin
            unf_set = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_r <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            flags_r <= flags_nx;
            count_r <= count_nx;
            full_r  <= (count_nx == CW'(DEPTH));
            empty_r <= (count_nx == '0);
            if (stk_we) begin
                stack[stk_idx] <= flags_r;
            end
            if (ovf_set) begin
                ovf_r <= 1'b1;
            end
            if (unf_set) begin
                unf_r <= 1'b1;
            end
        end
    end

    assign bus.flags   = flags_r;
    assign bus.count   = count_r;
    assign bus.full    = full_r;
    assign bus.empty   = empty_r;
    assign bus.ovf_err = ovf_r;
    assign bus.unf_err = unf_r;
`ifdef FLAG_STACK_FWD_EN
    assign bus.flags_fwd = flags_nx;
`endif

endmodule

// File: tb/tb_flag_stack_register.sv
// tb_flag_stack_register
//   Directed and randomized stimulus for flag_stack_register, compared
//   against a queue-based reference model. With FLAG_STACK_FWD_EN defined
//   flags_fwd is also compared against the model's predicted next flags.
module tb_flag_stack_register;
    localparam int NF = 3;
    localparam int DP = 4;

    logic clk;
    logic rst;

    flag_stack_register_if #(.NFLAGS(NF), .DEPTH(DP)) bus ();

    flag_stack_register #(.NFLAGS(NF), .DEPTH(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: flags value, stack as a queue (back = top), sticky errors.
    logic [NF-1:0] m_flags;
    logic [NF-1:0] m_stk[$];
    bit            m_ovf;
    bit            m_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flags = '0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    function automatic logic [NF-1:0] wr_flags(input logic [NF-1:0] cur,
                                               input logic [NF-1:0] fi,
                                               input logic [NF-1:0] fw);
        logic [NF-1:0] r;
        for (int i = 0; i < NF; i++) r[i] = fw[i] ? fi[i] : cur[i];
        return r;
    endfunction

    function automatic logic [NF-1:0] predict(input logic [NF-1:0] fi, input logic [NF-1:0] fw,
                                              input bit pu, input bit po);
        if (po && m_stk.size() > 0) return m_stk[m_stk.size()-1];
        return wr_flags(m_flags, fi, fw);
    endfunction

    task automatic model_step(input logic [NF-1:0] fi, input logic [NF-1:0] fw,
                              input bit pu, input bit po);
        logic [NF-1:0] old;
        old = m_flags;
        if (po && m_stk.size() > 0) begin
            if (pu) begin
                m_flags = m_stk[m_stk.size()-1];
                m_stk[m_stk.size()-1] = old;
            end else begin
                m_flags = m_stk.pop_back();
            end
        end else begin
            if (pu) begin
                if (m_stk.size() < DP) m_stk.push_back(old);
                else m_ovf = 1'b1;
            end else if (po) begin
                m_unf = 1'b1;
            end
            m_flags = wr_flags(old, fi, fw);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".flags"},   32'(bus.flags),   32'(m_flags));
        check({tag, ".count"},   32'(bus.count),   32'(m_stk.size()));
        check({tag, ".full"},    32'(bus.full),    32'(m_stk.size() == DP));
        check({tag, ".empty"},   32'(bus.empty),   32'(m_stk.size() == 0));
        check({tag, ".ovf_err"}, 32'(bus.ovf_err), 32'(m_ovf));
        check({tag, ".unf_err"}, 32'(bus.unf_err), 32'(m_unf));
    endtask

    // Called away from the edge; drives one cycle and checks after it.
    task automatic cycle(input string tag, input logic [NF-1:0] fi, input logic [NF-1:0] fw,
                         input bit pu, input bit po);
        logic [NF-1:0] exp_next;
        bus.flags_in  = fi;
        bus.flags_wen = fw;
        bus.push      = pu;
        bus.pop       = po;
        exp_next      = predict(fi, fw, pu, po);
        #1;
`ifdef FLAG_STACK_FWD_EN
        check({tag, ".flags_fwd"}, 32'(bus.flags_fwd), 32'(exp_next));
`else
        exp_next = exp_next;
`endif
        @(posedge clk);
        model_step(fi, fw, pu, po);
        #1;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.flags_wen = '0;
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NF-1:0] seq [5];
        seq[0] = 3'b010; seq[1] = 3'b011; seq[2] = 3'b100; seq[3] = 3'b110; seq[4] = 3'b111;

        rst = 1'b0;
        bus.flags_in = '0; bus.flags_wen = '0; bus.push = 1'b0; bus.pop = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all("reset");
        @(negedge clk) rst = 1'b1;
        cycle("idle", '0, '0, 0, 0);

        // Masked writes
        cycle("wr_all",  3'b101, 3'b111, 0, 0);
        check("wr_all.val", 32'(bus.flags), 32'h5);
        cycle("wr_bit0", 3'b010, 3'b001, 0, 0);
        check("wr_bit0.val", 32'(bus.flags), 32'h4);

        // Push with write, then pop ignoring write
        cycle("set101", 3'b101, 3'b111, 0, 0);
        cycle("push1",  3'b011, 3'b111, 1, 0);
        check("push1.val", 32'(bus.flags), 32'h3);
        cycle("pop1",   3'b000, 3'b111, 0, 1);
        check("pop1.val", 32'(bus.flags), 32'h5);

        // Exchange at count=1, then push+pop on empty
        cycle("set110", 3'b110, 3'b111, 0, 0);
        cycle("push110", 3'b001, 3'b111, 1, 0);
        cycle("xchg",   3'b000, 3'b111, 1, 1);
        check("xchg.val", 32'(bus.flags), 32'h6);
        cycle("pop_x",  3'b000, 3'b000, 0, 1);
        check("pop_x.val", 32'(bus.flags), 32'h1);
        cycle("xchg_empty", 3'b101, 3'b111, 1, 1);
        check("xchg_empty.unf", 32'(bus.unf_err), 32'h0);
        cycle("drain", 3'b000, 3'b000, 0, 1);

        // Fill, overflow, drain, underflow
        cycle("set001", 3'b001, 3'b111, 0, 0);
        for (int i = 0; i < 5; i++) cycle("fill", seq[i], 3'b111, 1, 0);
        check("fill.ovf", 32'(bus.ovf_err), 32'h1);
        check("fill.count", 32'(bus.count), 32'h4);
        for (int i = 0; i < 4; i++) cycle("restore", 3'b000, 3'b000, 0, 1);
        check("restore.last", 32'(bus.flags), 32'h1);
        cycle("underflow", 3'b000, 3'b000, 0, 1);
        check("underflow.unf", 32'(bus.unf_err), 32'h1);

        // Asynchronous reset between edges during a push at count=2
        cycle("pre_a", 3'b011, 3'b111, 1, 0);
        cycle("pre_b", 3'b100, 3'b111, 1, 0);
        bus.flags_in = 3'b111; bus.flags_wen = 3'b111; bus.push = 1'b1;
        #3 rst = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        @(posedge clk);
        #1 check_all("async_hold");
        bus.push = 1'b0; bus.flags_wen = '0;
        @(negedge clk) rst = 1'b1;
        #1;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cycle("rand", NF'($urandom), NF'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
